nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that computes a WIDTH-bit add by time-multiplexing one 4-bit ripple-carry slice, one nibble per clock, from least significant to most significant. Between nibbles the slice's carry-out is registered and fed back as the next carry-in. Operands arrive on a valid/ready request port and results leave on a valid/ready response port. It sits in front of arithmetic consumers that can tolerate multi-cycle latency in exchange for a single small adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request
a  input  WIDTH  operand A, sampled on acceptance
b  input  WIDTH  operand B, sampled on acceptance
cin  input  1  carry-in, sampled on acceptance
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, registered
cout  output  1  final carry-out, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch a, b and cin (carry register<=cin), set index=0, go to RUN.
  - sum and cout keep the previous result.
- RUN:
  - in_ready=0.
  - Each edge: sum[4*idx+:4] <= slice sum of a_q[idx], b_q[idx] and the carry register; carry register <= slice carry-out; idx++.
  - On the edge where idx==NIB-1: cout <= slice carry-out, out_valid <= 1, go to DONE.
  - Sum nibbles above idx hold stale data and are undefined to the consumer until out_valid.
- DONE:
  - out_valid=1. sum and cout are stable and must not change while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - No new request is accepted in the same cycle. in_ready rises the next cycle, so there is one bubble.
- Latency: out_valid is high exactly NIB cycles after the acceptance edge. With WIDTH=16, out_valid rises after the 4th edge.
- Throughput: at most one result per NIB+2 cycles.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). The result is exact with no saturation.
- WIDTH=4 is a degenerate case: RUN lasts one cycle.
- in_valid asserted while in RUN or DONE is ignored. The request must be held by the producer under the standard valid/ready rule.
- Reset mid-operation:
  - All state returns to the reset values immediately (asynchronously).
  - A partial result is discarded and out_valid drops without a handshake.
- out_ready is a don't-care outside DONE.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input op_sub (1 bit, sampled on acceptance) and output ovf (WIDTH-independent, 1 bit, registered, reset 0).
  - With op_sub=1: each b nibble is inverted before the slice and the initial carry register is forced to 1 (cin ignored), giving sum = a - b. cout is then the not-borrow.
  - ovf is the signed overflow of the final nibble (carry into MSB XOR carry out of MSB). It is written with cout and is valid only with out_valid.
- When undefined: the ports do not exist and behaviour is add-only as above.

Decomposition:
- Shared package nibble_add_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - localparam NIB_W=4
  - a function computing index width, $clog2(NIB) with minimum 1.
- One natural sub-module: add4_slice, a purely combinational 4-bit full-add slice with ports a4, b4, ci, s4, co (plus c3 for ovf under the macro).
- The controller owns all registers.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after acceptance; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Checks carry propagation across all nibble boundaries.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0. Then hold out_ready=0 for 5 cycles -> sum, cout and out_valid stay constant and in_ready stays 0.
- Assert in_valid continuously with back-to-back requests 0x00FF+0x0F01 and 0x8000+0x8000 -> results 0x1000/0 then 0x0000/1, each separated by NIB+2 cycles.
- Pull rst_n low after the 2nd RUN edge -> out_valid=0, in_ready=1 and sum=0 immediately. After release, a fresh 0x0001+0x0001 returns 0x0002.
- With SERIAL_ADD_SUB_EN: op_sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add_pkg
//  Description : Shared definitions for the nibble-serial adder controller:
//                controller state encoding, slice width and the helper that
//                sizes the nibble index register.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_add_pkg;

    // Width of the shared ripple-carry slice.
    localparam int NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Explicit-width state constants used by the state register; tied to
    // the enum so the two encodings can never drift apart.
    localparam int         STATE_W = 2;
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    // Bits needed to hold a nibble index 0..nib-1; never narrower than 1 so
    // the degenerate single-nibble build still has a legal register.
    function automatic int idx_width(input int nib);
        return (nib <= 2) ? 1 : $clog2(nib);
    endfunction

endpackage : nibble_add_pkg
`default_nettype wire

// File: rtl/add4_slice.sv
`default_nettype none
// ============================================================================
//  Module      : add4_slice
//  Description : Purely combinational 4-bit full-add slice shared by every
//                nibble of the serial add.
//  Ports       : a4, b4 - nibble operands
//                ci     - carry in
//                s4     - nibble sum
//                co     - carry out of bit 3
//                c3     - carry into bit 3 (SERIAL_ADD_SUB_EN builds only,
//                         used for signed overflow of the top nibble)
//  Options     : SERIAL_ADD_SUB_EN adds the c3 output.
//  Revision    : 1.0 - initial release
// ============================================================================
module add4_slice
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a4,
    input  logic [NIB_W-1:0] b4,
    input  logic             ci,
    output logic [NIB_W-1:0] s4,
    output logic             co
`ifdef SERIAL_ADD_SUB_EN
    ,
    output logic             c3
`endif
);

    logic [NIB_W:0] w_total;

    assign w_total = {1'b0, a4} + {1'b0, b4} + {{NIB_W{1'b0}}, ci};
    assign s4      = w_total[NIB_W-1:0];
    assign co      = w_total[NIB_W];

`ifdef SERIAL_ADD_SUB_EN
    // The carry into the top bit is recovered from that bit's sum and
    // operands: s = a ^ b ^ c  =>  c = s ^ a ^ b.
    assign c3 = s4[NIB_W-1] ^ a4[NIB_W-1] ^ b4[NIB_W-1];
`endif

endmodule : add4_slice
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_ctrl
//  Description : WIDTH-bit adder built from one 4-bit slice reused once per
//                clock, LSB nibble first, with the slice carry registered
//                between nibbles. Valid/ready request and response ports.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                in_valid/in_ready    - request handshake
//                a, b, cin            - operands, sampled on acceptance
//                out_valid/out_ready  - response handshake
//                sum, cout            - registered result
//                busy                 - high while RUN or DONE
//                op_sub, ovf          - subtract select / signed overflow
//                                       (SERIAL_ADD_SUB_EN builds only)
//  Options     : SERIAL_ADD_SUB_EN enables a - b via inverted b and forced
//                carry-in, plus the ovf flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_SUB_EN
    ,
    input  logic             op_sub,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = idx_width(NIB);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [STATE_W-1:0] r_state;
    logic [IW-1:0]      r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_out_valid;

    logic [NIB_W-1:0]   w_a4;
    logic [NIB_W-1:0]   w_b4;
    logic [NIB_W-1:0]   w_s4;
    logic               w_co;
    logic               w_last;

`ifdef SERIAL_ADD_SUB_EN
    logic               r_sub;
    logic               r_ovf;
    logic               w_c3;
`endif

    // Operand registers shift right one nibble per RUN cycle, so the slice
    // always sees the current nibble in the low bits.
    assign w_a4 = r_a[NIB_W-1:0];
`ifdef SERIAL_ADD_SUB_EN
    assign w_b4 = r_b[NIB_W-1:0] ^ {NIB_W{r_sub}};
`else
    assign w_b4 = r_b[NIB_W-1:0];
`endif

    assign w_last = (r_idx == IW'(NIB - 1));

    add4_slice u_slice (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
`ifdef SERIAL_ADD_SUB_EN
        ,
        .c3 (w_c3)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub       <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        r_sub   <= op_sub;
                        // Two's-complement subtract: ~b plus a forced 1.
                        r_carry <= op_sub ? 1'b1 : cin;
`else
                        r_carry <= cin;
`endif
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[k*NIB_W +: NIB_W] <= w_s4;
                        end
                    end
                    r_carry <= w_co;
                    r_a     <= r_a >> NIB_W;
                    r_b     <= r_b >> NIB_W;
                    if (w_last) begin
                        r_cout      <= w_co;
`ifdef SERIAL_ADD_SUB_EN
                        r_ovf       <= w_co ^ w_c3;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                S_DONE: begin
                    // Return to IDLE only; the next request waits one cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERIAL_ADD_SUB_EN
    assign ovf       = r_ovf;
`endif

endmodule : nibble_serial_adder_ctrl
`default_nettype wire
